instr_encoder: RTL
==================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4: output FIFO entries, power of two, 2 to 16.
REQ-002 The block SHALL have parameter ADDR_BASE, default 32'h0: first instruction address emitted.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 Port clk, input, 1: rising-edge clock for all state.
REQ-005 Port reset, input, 1: synchronous active-high reset.
REQ-006 Port in_valid, input, 1: field bundle present.
REQ-007 Port in_ready, output, 1: bundle accepted when in_valid && in_ready.
REQ-008 Port in_cls, input, 4: class: 0 R, 1 OPIMM, 2 LOAD, 3 STORE, 4 BRANCH, 5 LUI, 6 AUIPC, 7 JAL, 8 JALR; 9-15 illegal.
REQ-009 Port in_funct3, input, 3: funct3 field.
REQ-010 Port in_alt, input, 1: selects funct7 = 7'b0100000 (sub, sra, srai).
REQ-011 Ports in_rd, in_rs1 and in_rs2, input, 5 each: register indices.
REQ-012 Port in_imm, input, 32: signed immediate, byte offset for BRANCH/JAL.
REQ-013 Port out_valid, output, 1: FIFO head valid.
REQ-014 Port out_ready, input, 1: consumer takes head when out_valid && out_ready.
REQ-015 Port out_instr, output, 32: encoded RV32I word at head.
REQ-016 Port out_addr, output, 32: instruction address of head entry.
REQ-017 Port count, output, $clog2(DEPTH)+1: FIFO occupancy.
REQ-018 Port err, output, 1: sticky illegal-request flag.

Function
REQ-019 Opcodes SHALL be: R 0110011, OPIMM 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111.
REQ-020 Field placement SHALL follow RV32I R/I/S/B/U/J formats exactly; unused fields (e.g. rs2 for I-type, rd for S/B) SHALL be taken from in_imm, not the register ports.
REQ-021 funct7 SHALL be 0100000 when in_alt=1 for R, and for OPIMM with funct3=101; otherwise 0000000. OPIMM shifts SHALL place in_imm[4:0] in bits 24:20.
REQ-022 A request SHALL be illegal if any of these hold: in_cls>8; R with in_alt and funct3 not 000/101; OPIMM funct3=001 with in_alt; OPIMM shift with in_imm[31:5]!=0; OPIMM funct3 000, 010, 011, 100, 110 or 111 with in_alt; LOAD funct3 011, 110 or 111; STORE funct3>010; BRANCH funct3 010 or 011; JALR funct3!=000; BRANCH or JAL with in_imm[0]=1; in_imm not a sign-extension of 12 bits (I/S), 13 bits (B) or 21 bits (J); U-type with in_imm[11:0]!=0.
REQ-023 U-type SHALL place in_imm[31:12] in bits 31:12.
REQ-024 in_ready SHALL equal (count<DEPTH); it SHALL NOT depend on out_ready (no full-state pass-through).
REQ-025 A legal accepted request SHALL be written to the FIFO with the current address counter, and the counter SHALL advance by 4, wrapping modulo 2^32.
REQ-026 An illegal accepted request SHALL complete the handshake, SHALL NOT be enqueued, SHALL NOT advance the address counter, and SHALL set err from the next cycle until reset.
REQ-027 Latency SHALL be one cycle: a word accepted at edge N is at the head, or queued behind older entries, from edge N onward.
REQ-028 Output SHALL be in acceptance order. out_instr and out_addr SHALL be stable while out_valid && !out_ready.
REQ-029 On simultaneous push and pop when 0<count<DEPTH, count SHALL be unchanged. A push into an empty FIFO SHALL make out_valid 1 on the next cycle.
REQ-030 out_instr and out_addr SHALL be 0 when out_valid=0.

Reset
REQ-031 On reset, the block SHALL set count=0, out_valid=0, in_ready=1, err=0, the address counter to ADDR_BASE, and out_instr and out_addr to 0.
REQ-032 Reset mid-operation SHALL discard all queued entries; a handshake in the reset cycle SHALL be ignored.

Verification
REQ-033 R and S encoding: cls0 f3=000 rd=10 rs1=5 rs2=6 alt=0, then cls3 f3=010 rs1=5 rs2=7 imm=4 -> out 0x00628533 at addr 0x0, then 0x0072A223 at addr 0x4.
REQ-034 Shift encoding: cls1 f3=101 alt=1 rd=10 rs1=5 imm=2 (srai) -> 0x4022D513.
REQ-035 Illegal requests: slli with imm=32, then BRANCH with imm=3 -> both accepted, no output, err=1, next legal word at unchanged address.
REQ-036 Full FIFO: DEPTH=4, out_ready=0, 5 legal requests -> in_ready=0 after the 4th, count=4; then out_ready=1 -> words drain in order at addrs 0, 4, 8, 12, then the 5th at 16.
REQ-037 Simultaneous push/pop at count=2 -> count stays 2; reset asserted with count=3 and err=1 -> next cycle count=0, out_valid=0, err=0, next address = ADDR_BASE.

Source files
------------

// File: rtl/instr_encoder.sv
// instr_encoder
//   Turns a decoded field bundle (class, funct3, alt, registers, immediate)
//   into an RV32I instruction word. Legal words are queued with their
//   instruction address in a DEPTH-entry FIFO. Illegal requests are
//   consumed but dropped, and they set a sticky error flag.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready.
//   Valid never waits on ready. in_ready depends only on FIFO occupancy.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   request handshake
//   in_cls, in_funct3, in_alt, in_rd, in_rs1, in_rs2, in_imm   request fields
//   out_valid/out_ready head-of-FIFO handshake
//   out_instr, out_addr encoded word and its address (0 when empty)
//   count               FIFO occupancy
//   err                 sticky illegal-request flag
module instr_encoder #(
   parameter int unsigned DEPTH     = 4,
   parameter logic [31:0] ADDR_BASE = 32'h0
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [3:0]               in_cls,
   input  logic [2:0]               in_funct3,
   input  logic                     in_alt,
   input  logic [4:0]               in_rd,
   input  logic [4:0]               in_rs1,
   input  logic [4:0]               in_rs2,
   input  logic [31:0]              in_imm,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [31:0]              out_instr,
   output logic [31:0]              out_addr,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     err
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   // ---------------- encoder ----------------
   logic [31:0] word_enc;
   logic        illegal;
   logic [6:0]  funct7;
   logic        sx12, sx13, sx21;
   logic        f3_shift;

   // Immediate fits in N signed bits when all bits above N-1 match bit N-1.
   assign sx12 = (&in_imm[31:11]) | ~(|in_imm[31:11]);
   assign sx13 = (&in_imm[31:12]) | ~(|in_imm[31:12]);
   assign sx21 = (&in_imm[31:20]) | ~(|in_imm[31:20]);
   assign f3_shift = (in_funct3 == 3'b001) || (in_funct3 == 3'b101);

   always_comb begin
      word_enc = '0;
      illegal  = 1'b0;
      funct7   = 7'b0000000;
      case (in_cls)
         4'd0: begin // R
            funct7   = in_alt ? 7'b0100000 : 7'b0000000;
            word_enc = {funct7, in_rs2, in_rs1, in_funct3, in_rd, 7'b0110011};
            if (in_alt && !(in_funct3 == 3'b000 || in_funct3 == 3'b101)) illegal = 1'b1;
         end
         4'd1: begin // OPIMM
            if (f3_shift) begin
               // Shift amount lives in the rs2 slot; alt only meaningful for srai.
               funct7   = (in_alt && in_funct3 == 3'b101) ? 7'b0100000 : 7'b0000000;
               word_enc = {funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, 7'b0010011};
               if (in_alt && in_funct3 == 3'b001) illegal = 1'b1;
               if (|in_imm[31:5])                 illegal = 1'b1;
            end else begin
               word_enc = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0010011};
               if (in_alt || !sx12) illegal = 1'b1;
            end
         end
         4'd2: begin // LOAD
            word_enc = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0000011};
            if (in_funct3 == 3'b011 || in_funct3 == 3'b110 || in_funct3 == 3'b111) illegal = 1'b1;
            if (!sx12) illegal = 1'b1;
         end
         4'd3: begin // STORE
            word_enc = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], 7'b0100011};
            if (in_funct3 > 3'b010 || !sx12) illegal = 1'b1;
         end
         4'd4: begin // BRANCH
            word_enc = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                        in_imm[4:1], in_imm[11], 7'b1100011};
            if (in_funct3 == 3'b010 || in_funct3 == 3'b011) illegal = 1'b1;
            if (in_imm[0] || !sx13) illegal = 1'b1;
         end
         4'd5: begin // LUI
            word_enc = {in_imm[31:12], in_rd, 7'b0110111};
            if (|in_imm[11:0]) illegal = 1'b1;
         end
         4'd6: begin // AUIPC
            word_enc = {in_imm[31:12], in_rd, 7'b0010111};
            if (|in_imm[11:0]) illegal = 1'b1;
         end
         4'd7: begin // JAL
            word_enc = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, 7'b1101111};
            if (in_imm[0] || !sx21) illegal = 1'b1;
         end
         4'd8: begin // JALR
            word_enc = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b1100111};
            if (in_funct3 != 3'b000 || !sx12) illegal = 1'b1;
         end
         default: illegal = 1'b1;
      endcase
   end

   // ---------------- FIFO and address counter ----------------
   logic [31:0]   mem_instr_q [DEPTH];
   logic [31:0]   mem_addr_q  [DEPTH];
   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW-1:0] rptr_q, rptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [31:0]   addr_q, addr_d;
   logic          err_q, err_d;
   logic          accept, push, pop;

   assign in_ready  = (count_q < DEPTH_C);
   assign out_valid = (count_q != '0);
   assign accept    = in_valid && in_ready;
   assign push      = accept && !illegal;
   assign pop       = out_valid && out_ready;

   always_comb begin
      wptr_d  = push ? wptr_q + AW'(1) : wptr_q;
      rptr_d  = pop  ? rptr_q + AW'(1) : rptr_q;
      addr_d  = push ? addr_q + 32'd4  : addr_q;
      err_d   = err_q | (accept && illegal);
      count_d = count_q;
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         addr_q  <= ADDR_BASE;
         err_q   <= 1'b0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         addr_q  <= addr_d;
         err_q   <= err_d;
      end
   end

   // Storage needs no reset: an entry written during reset is orphaned
   // because the pointers and count are cleared in the same cycle.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_instr_q[wptr_q] <= word_enc;
         mem_addr_q[wptr_q]  <= addr_q;
      end
   end

   assign out_instr = out_valid ? mem_instr_q[rptr_q] : 32'h0;
   assign out_addr  = out_valid ? mem_addr_q[rptr_q]  : 32'h0;
   assign count     = count_q;
   assign err       = err_q;

endmodule
